// File: rtl/approx_4_2_reduce_pipe_if.sv
// Streaming bundle for the approximate 4:2 reducer.
// Carries the row-set input handshake (in_valid/in_ready, r0..r3) and the
// result output handshake (out_valid/out_ready, res).
//   master : upstream/downstream environment (drives rows and out_ready)
//   slave  : the reducer itself
interface approx_4_2_reduce_pipe_if #(
  parameter int unsigned W = 8
);
  localparam int unsigned OW = W + 2;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  r0;
  logic [W-1:0]  r1;
  logic [W-1:0]  r2;
  logic [W-1:0]  r3;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] res;

  modport master (
    output in_valid, r0, r1, r2, r3, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, r0, r1, r2, r3, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/approx_4_2_reduce_pipe.sv
// Two-stage pipelined 4-row partial-product reducer.
// Stage 1 compresses every bit column with an approximate sorting-network
// 4:2 compressor (four ones count as three); stage 2 merges the Sum/Carry
// vectors with an exact adder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of approx_4_2_reduce_pipe_if (in/out handshakes)
//   err_cnt    : 16-bit saturating count of four-ones columns seen at input,
//                present only when APPROX_ERR_CNT_EN is defined
module approx_4_2_reduce_pipe #(
  parameter int unsigned W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  approx_4_2_reduce_pipe_if.slave     bus
`ifdef APPROX_ERR_CNT_EN
  ,
  output logic [15:0]                 err_cnt
`endif
);
  localparam int unsigned OW = W + 2;

  logic          s1_valid;
  logic [W-1:0]  s1_s;
  logic [W-1:0]  s1_c;
  logic          out_valid;
  logic [OW-1:0] res;

  logic          s2_free;
  logic          move;
  logic          accept;

  logic [W-1:0]  p_hi, p_lo, q_hi, q_lo;
  logic [W-1:0]  h1, a_mid, h2;
  logic [W-1:0]  col_s, col_c;
  logic [OW-1:0] merge_c;

  // Flow control: stage 2 can take data if empty or draining this cycle
  assign s2_free      = !out_valid || bus.out_ready;
  assign move         = s1_valid && s2_free;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid;
  assign bus.res       = res;

  // Sorting network: h1 = (n>=1), a_mid = (n>=2), h2 = (n>=3)
  assign p_hi  = bus.r0 | bus.r1;
  assign p_lo  = bus.r0 & bus.r1;
  assign q_hi  = bus.r2 | bus.r3;
  assign q_lo  = bus.r2 & bus.r3;
  assign h1    = p_hi | q_hi;
  assign a_mid = (p_hi & q_hi) | (p_lo | q_lo);
  assign h2    = (p_hi & q_hi) & (p_lo | q_lo);
  assign col_c = h1 & a_mid;
  assign col_s = (h1 ^ a_mid) | h2;

  // Exact merge of the registered Sum/Carry vectors
  assign merge_c = OW'(s1_s) + (OW'(s1_c) << 1);

  // Stage 1: compress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_c     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_s     <= col_s;
        s1_c     <= col_c;
      end else if (move) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: merge; holds while stalled, clears only on a pop with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else begin
      if (move) begin
        out_valid <= 1'b1;
        res       <= merge_c;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef APPROX_ERR_CNT_EN
  localparam int unsigned PW = $clog2(W + 1);

  logic [W-1:0]  all4;
  logic [PW-1:0] n4_cnt;
  logic [16:0]   err_sum;

  assign all4 = bus.r0 & bus.r1 & bus.r2 & bus.r3;

  // Number of columns where the compressor under-counts
  always_comb begin
    n4_cnt = '0;
    for (int i = 0; i < int'(W); i++) begin
      n4_cnt = n4_cnt + PW'(all4[i]);
    end
  end

  assign err_sum = 17'(err_cnt) + 17'(n4_cnt);

  // Saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept) begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/approx_4_2_reduce_pipe.md
Name: approx_4_2_reduce_pipe

Overview:
- Pipelined 4-row partial-product reducer.
- Each bit column is reduced by the sorting-network approximate 4:2 compressor function; an exact adder then merges the resulting Sum/Carry vectors.
- Sits downstream of the partial-product generator and upstream of the multiplier accumulator.
- Streaming valid/ready interfaces on input and output, with full backpressure.

Parameters:
- W, 8, width of each input row (bits).
- OW, W+2, output width; fixed by derivation and not overridden by the user.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  row set on r0..r3 is valid.
- in_ready  output  1  block accepts the row set this cycle.
- r0  input  W  partial-product row 0.
- r1  input  W  partial-product row 1.
- r2  input  W  partial-product row 2.
- r3  input  W  partial-product row 3.
- out_valid  output  1  res holds a valid result.
- out_ready  input  1  downstream accepts res this cycle.
- res  output  OW  reduced sum.
- err_cnt  output  16  present only with APPROX_ERR_CNT_EN.

Behaviour:
- Column function, per bit i. Let n = r0[i]+r1[i]+r2[i]+r3[i].
  - n=0 → S=0, C=0
  - n=1 → S=1, C=0
  - n=2 → S=0, C=1
  - n=3 → S=1, C=1
  - n=4 → S=1, C=1 (approximate; under-counts by 1)
  - Implemented as the max/min sorting network: Carry = h1&A, Sum = (h1^A)|h2.
- Stage 1 (compress):
  - On handshake (in_valid & in_ready), register S[W-1:0] and C[W-1:0].
  - s1_valid <= 1.
- Stage 2 (merge):
  - On stage advance, register res = zero-extend(S) + (zero-extend(C) << 1), computed in OW bits.
  - out_valid <= 1.
  - No overflow possible: the maximum is 3*(2^W-1) < 2^OW.
- Handshake and flow:
  - s2_free = !out_valid | out_ready.
  - Stage 1→2 move occurs when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free (combinational; no dependency on in_valid).
  - When out_valid=1 and out_ready=0: res and out_valid hold stable.
  - out_valid is cleared only on out_ready when no new data moves in.
- Latency: 2 cycles from input handshake to out_valid. Throughput: 1 result/cycle when out_ready stays high.
- Capacity: 2 entries in flight. A third row set is refused (in_ready=0) while both stages are full and out_ready=0.
- Simultaneous events:
  - Input accept, stage move and output pop may occur in the same cycle; no bubble is inserted.
  - Order is strictly preserved.
- Reset:
  - rst_n low, asynchronously, clears s1_valid, out_valid, S, C and res to 0.
  - In-flight data is discarded.
  - in_ready reads 1 while in reset.
  - Leaving reset resumes normal operation on the first clk edge with rst_n high.
- Registered data is not cleared when a stage empties; it stays don't-care while the corresponding valid is 0.

Optional Feature:
- Macro: APPROX_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (16-bit, reset 0).
  - On each input handshake, err_cnt increments by the number of columns with n=4, i.e. popcount(r0&r1&r2&r3).
  - Saturates at 0xFFFF.
- Undefined:
  - Port and counter are absent.
  - Datapath and timing are identical.

Test Plan:
- Reset → with rst_n=0: out_valid=0, res=0, in_ready=1. Release reset, apply no input → out_valid stays 0.
- W=8, r0=0x01, r1=0x01, r2=r3=0x00, out_ready=1 → two cycles later: out_valid=1, res=0x002. Exact case.
- r0=0x0F, r1=0xF0, r2=0x33, r3=0xCC → res=0x1FE (510); matches the exact sum. Macro defined: err_cnt unchanged.
- r0=r1=r2=r3=0xFF → res=0x2FD (765, versus exact 1020). Macro defined: err_cnt increases by 8.
- Backpressure:
  - out_ready=0; offer three back-to-back sets (1,0,0,0), (2,0,0,0), (3,0,0,0).
  - Required: the first two are accepted, then in_ready=0; res=0x001 held stable.
  - Raise out_ready → results 1, 2, 3 emerge in order, none lost or duplicated.
- Pull rst_n low mid-stream with both stages full → out_valid=0 immediately (asynchronous). After release, a new input (0x01,0,0,0) yields res=0x001 only; no stale results appear.
